// File: rtl/accel_pkg.sv
// Shared types for the accelerator command path.
//   control_packet_t : host command word (unit_id, op_code, comp_type, reserved)
//   dispatch_state_t : dispatcher FSM states
//   CTRL_PKT_W       : width of a command word
package accel_pkg;

    localparam int NUM_PROCESSING_UNITS = 4;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_COMP  = 3'b011,
        OP_SYNC  = 3'b100
    } operation_code_t;

    typedef enum logic [2:0] {
        CT_ADD  = 3'b000,
        CT_SUB  = 3'b001,
        CT_MUL  = 3'b010,
        CT_MAC  = 3'b011,
        CT_RELU = 3'b100
    } computation_type_t;

    typedef struct packed {
        logic [3:0]        unit_id;
        operation_code_t   op_code;
        computation_type_t comp_type;
        logic [3:0]        reserved;
    } control_packet_t;

    localparam int CTRL_PKT_W = $bits(control_packet_t);

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_DECODE,
        DS_SYNC_WAIT
    } dispatch_state_t;

    // Commands that occupy a processing unit.
    function automatic logic is_issue_op(input operation_code_t op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_COMP);
    endfunction

endpackage

// File: rtl/accel_cmd_fifo.sv
// Single-clock command FIFO with first-word-fall-through output.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/level only)
//   push, din  : write din when push and not full
//   pop        : advance head when pop and not empty
//   dout       : current head word (valid whenever empty=0)
//   full/empty : occupancy flags
//   level      : occupancy, 0..DEPTH
module accel_cmd_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/accel_cmd_dispatcher.sv
// Front-end command stage: buffers host commands and issues them in order
// to the processing units, tracking per-unit busy state and OP_SYNC barriers.
//   clk, rst_n   : clock, asynchronous active-low reset
//   s_valid/s_ready/s_pkt : host command stream (s_ready = FIFO not full)
//   unit_start   : one-hot 1-cycle start pulse to the target unit
//   unit_op/unit_comp : fields of the issued command, held between issues
//   unit_done    : per-unit completion pulse
//   unit_busy    : registered busy flags
//   sync_done    : 1-cycle pulse when a barrier releases
//   err_bad_unit : sticky, a command addressed a non-existent unit
//   fifo_level   : command FIFO occupancy
module accel_cmd_dispatcher
    import accel_pkg::*;
#(
    parameter int NUM_UNITS      = NUM_PROCESSING_UNITS,
    parameter int CMD_FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [CTRL_PKT_W-1:0]             s_pkt,
    output logic [NUM_UNITS-1:0]              unit_start,
    output logic [2:0]                        unit_op,
    output logic [2:0]                        unit_comp,
    input  logic [NUM_UNITS-1:0]              unit_done,
    output logic [NUM_UNITS-1:0]              unit_busy,
    output logic                              sync_done,
    output logic                              err_bad_unit,
    output logic [$clog2(CMD_FIFO_DEPTH):0]   fifo_level
);

    localparam int UID_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [CTRL_PKT_W-1:0] fifo_dout;

    control_packet_t       cmd_q;
    dispatch_state_t       state;
    dispatch_state_t       state_nxt;
    logic [NUM_UNITS-1:0]  start_nxt;
    logic                  sync_nxt;
    logic                  err_set;
    logic [UID_W-1:0]      uid;
    logic                  uid_ok;
    logic                  unused_reserved;

    // s_ready depends only on occupancy, so a same-cycle pop never opens it.
    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && !fifo_full;

    accel_cmd_fifo #(
        .WIDTH (CTRL_PKT_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (s_pkt),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign uid             = cmd_q.unit_id[UID_W-1:0];
    assign uid_ok          = (int'(cmd_q.unit_id) < NUM_UNITS);
    assign unused_reserved = ^cmd_q.reserved;

    // Next state and next output values. Decode looks at the registered busy
    // vector, so a done arriving while decode waits is seen one edge later.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        start_nxt = '0;
        sync_nxt  = 1'b0;
        err_set   = 1'b0;
        case (state)
            DS_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = DS_DECODE;
                end
            end
            DS_DECODE: begin
                state_nxt = DS_IDLE;
                if (is_issue_op(cmd_q.op_code)) begin
                    if (!uid_ok) begin
                        err_set = 1'b1;
                    end else if (unit_busy[uid]) begin
                        state_nxt = DS_DECODE;
                    end else begin
                        start_nxt[uid] = 1'b1;
                    end
                end else if (cmd_q.op_code == OP_SYNC) begin
                    state_nxt = DS_SYNC_WAIT;
                end
                // NOP and undefined op codes fall through to idle.
            end
            DS_SYNC_WAIT: begin
                if (unit_busy == '0) begin
                    sync_nxt  = 1'b1;
                    state_nxt = DS_IDLE;
                end
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_pop) cmd_q <= control_packet_t'(fifo_dout);
    end

    // Issue only targets an idle unit, so setting and clearing the same bit
    // in one cycle cannot happen; done to an idle unit is masked away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_start   <= '0;
            unit_busy    <= '0;
            unit_op      <= '0;
            unit_comp    <= '0;
            sync_done    <= 1'b0;
            err_bad_unit <= 1'b0;
        end else begin
            unit_start <= start_nxt;
            unit_busy  <= (unit_busy & ~unit_done) | start_nxt;
            sync_done  <= sync_nxt;
            if (err_set) err_bad_unit <= 1'b1;
            if (|start_nxt) begin
                unit_op   <= cmd_q.op_code;
                unit_comp <= cmd_q.comp_type;
            end
        end
    end

endmodule

// File: tb/tb_accel_cmd_dispatcher.sv
// Scoreboard bench for accel_cmd_dispatcher: accepted commands are turned
// into expected issue/barrier events; a monitor matches DUT outputs in order.
module tb_accel_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [13:0] s_pkt;
    logic [3:0]  unit_start;
    logic [2:0]  unit_op;
    logic [2:0]  unit_comp;
    logic [3:0]  unit_done;
    logic [3:0]  unit_busy;
    logic        sync_done;
    logic        err_bad_unit;
    logic [3:0]  fifo_level;

    logic [3:0]  man_done = '0;
    logic [3:0]  auto_done = '0;
    assign unit_done = man_done | auto_done;

    accel_cmd_dispatcher #(.NUM_UNITS(4), .CMD_FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_pkt(s_pkt),
        .unit_start(unit_start), .unit_op(unit_op), .unit_comp(unit_comp),
        .unit_done(unit_done), .unit_busy(unit_busy), .sync_done(sync_done),
        .err_bad_unit(err_bad_unit), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_sync;
        int unit;
        int op;
        int comp;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   sync_cnt = 0;
    int   last_start_cyc = 0;
    int   last_sync_cyc = 0;
    logic [3:0] last_start_vec = '0;
    logic [3:0] model_busy = '0;
    logic [3:0] pend = '0;
    bit   bad_seen = 0;
    bit   auto_en = 0;
    bit   spur_en = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [13:0] mk(input int u, input int op, input int ct);
        return {4'(u), 3'(op), 3'(ct), 4'($urandom_range(0, 15))};
    endfunction

    // Reference rules: LOAD/STORE/COMP to units 0..3 issue in order,
    // to any other unit they are dropped with the error flag; SYNC
    // produces one barrier release; everything else produces nothing.
    function automatic void model_accept(input logic [13:0] p);
        int u;
        int op;
        int ct;
        u  = int'(p[13:10]);
        op = int'(p[9:7]);
        ct = int'(p[6:4]);
        if (op >= 1 && op <= 3) begin
            if (u < 4) exp_q.push_back('{1'b0, u, op, ct});
            else bad_seen = 1;
        end else if (op == 4) begin
            exp_q.push_back('{1'b1, 0, 0, 0});
        end
    endfunction

    // Monitor: sampled on the falling edge.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            model_busy = model_busy & ~pend;
            if (unit_start != 4'b0) begin
                chk("start_onehot", $countones(unit_start), 1);
                chk("start_to_idle_unit", unit_start & model_busy, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: got %b, expected no start", unit_start);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_issue", e.is_sync, 0);
                    chk("start_unit", unit_start, 1 << e.unit);
                    chk("unit_op", unit_op, e.op);
                    chk("unit_comp", unit_comp, e.comp);
                end
                start_cnt++;
                last_start_cyc = cyc;
                last_start_vec = unit_start;
                model_busy = model_busy | unit_start;
            end
            if (sync_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sync: got 1, expected 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_sync", e.is_sync, 1);
                end
                chk("sync_units_idle", model_busy, 0);
                sync_cnt++;
                last_sync_cyc = cyc;
            end
            chk("unit_busy", unit_busy, model_busy);
            chk("s_ready_vs_level", s_ready, fifo_level != 4'd8);
            chk("level_bound", fifo_level <= 4'd8, 1);
            if (!bad_seen) chk("err_without_cause", err_bad_unit, 0);
            pend = unit_done & model_busy;
        end
    end

    // Completion responder for the random phase.
    always @(posedge clk) begin
        #1;
        auto_done = '0;
        if (auto_en) begin
            for (int i = 0; i < 4; i++) begin
                if (model_busy[i] && $urandom_range(0, 2) == 0) auto_done[i] = 1'b1;
                else if (spur_en && $urandom_range(0, 19) == 0) auto_done[i] = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [13:0] pkt, input int max_wait, output bit ok);
        int  n;
        bit  acc;
        n = 0;
        ok = 0;
        s_valid = 1'b1;
        s_pkt = pkt;
        while (!ok && n < max_wait) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1;
                model_accept(pkt);
            end
            n++;
        end
        s_valid = 1'b0;
    endtask

    task automatic send_chk(input string name, input logic [13:0] pkt);
        bit ok;
        send(pkt, 20, ok);
        chk(name, ok, 1);
    endtask

    task automatic wait_start(input int prev, input int budget, input string name);
        int n = 0;
        while (start_cnt == prev && n < budget) begin
            step(1);
            n++;
        end
        chk(name, start_cnt != prev, 1);
    endtask

    task automatic wait_sync(input int prev, input int budget, input string name);
        int n = 0;
        while (sync_cnt == prev && n < budget) begin
            step(1);
            n++;
        end
        chk(name, sync_cnt != prev, 1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && model_busy == 4'b0 && fifo_level == 4'd0) && n < budget) begin
            step(1);
            n++;
        end
        step(4);
        chk(name, exp_q.size() == 0 && model_busy == 4'b0 && fifo_level == 4'd0, 1);
    endtask

    task automatic pulse_done(input logic [3:0] mask);
        man_done = mask;
        step(1);
        man_done = '0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        model_busy = '0;
        pend = '0;
        bad_seen = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int  prev;
        int  s0;
        int  acc_cyc;
        int  d;
        int  accepted;
        bit  ok;

        rst_n = 1'b1;
        s_valid = 1'b0;
        s_pkt = '0;
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_unit_start", unit_start, 0);
        chk("rst_unit_busy", unit_busy, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_err", err_bad_unit, 0);
        chk("rst_sync", sync_done, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);

        // 1: single COMP to unit 2, ADD
        prev = start_cnt;
        send_chk("t1_accept", mk(2, 3, 0));
        acc_cyc = cyc;
        wait_start(prev, 10, "t1_start_seen");
        chk("t1_latency", last_start_cyc - acc_cyc, 2);
        chk("t1_vec", last_start_vec, 4'b0100);
        chk("t1_op", unit_op, 3'b011);
        chk("t1_comp", unit_comp, 3'b000);
        chk("t1_pulse_one_cycle", unit_start, 0);
        chk("t1_busy", unit_busy, 4'b0100);
        pulse_done(4'b0100);
        step(2);

        // 2: back-to-back COMPs to unit 1, second waits for done
        prev = start_cnt;
        send_chk("t2_accept_a", mk(1, 3, 2));
        send_chk("t2_accept_b", mk(1, 3, 3));
        wait_start(prev, 10, "t2_first_start");
        step(8);
        chk("t2_no_early_start", start_cnt, prev + 1);
        d = cyc;
        pulse_done(4'b0010);
        wait_start(prev + 1, 10, "t2_second_start");
        chk("t2_start_after_done", last_start_cyc - d, 2);
        chk("t2_vec", last_start_vec, 4'b0010);
        pulse_done(4'b0010);
        step(3);

        // 3: fill while unit 0 never completes: one issued, one stalled in
        // decode, eight queued
        accepted = 0;
        for (int k = 0; k < 12; k++) begin
            send(mk(0, 3, k % 5), 3, ok);
            if (ok) accepted++;
        end
        chk("t3_accepted", accepted, 10);
        chk("t3_level_full", fifo_level, 8);
        chk("t3_s_ready_low", s_ready, 0);
        step(6);
        chk("t3_level_hold", fifo_level, 8);
        auto_en = 1;
        wait_drain(3000, "t3_drain");
        auto_en = 0;
        step(2);

        // 4: barrier behind LOAD u0 and STORE u3
        prev = start_cnt;
        s0 = sync_cnt;
        send_chk("t4_load", mk(0, 1, 1));
        send_chk("t4_store", mk(3, 2, 2));
        send_chk("t4_sync", mk(0, 4, 0));
        send_chk("t4_comp", mk(1, 3, 4));
        wait_start(prev, 10, "t4_load_start");
        wait_start(prev + 1, 10, "t4_store_start");
        step(4);
        chk("t4_no_sync_busy", sync_cnt, s0);
        pulse_done(4'b0001);
        step(4);
        chk("t4_no_sync_one_done", sync_cnt, s0);
        chk("t4_comp_held", start_cnt, prev + 2);
        d = cyc;
        pulse_done(4'b1000);
        wait_sync(s0, 10, "t4_sync_seen");
        chk("t4_sync_latency", last_sync_cyc - d, 2);
        wait_start(prev + 2, 10, "t4_comp_start");
        chk("t4_comp_after_sync", last_start_cyc - last_sync_cyc, 2);
        chk("t4_comp_vec", last_start_vec, 4'b0010);
        pulse_done(4'b0010);
        step(2);

        // 5: bad unit id
        prev = start_cnt;
        send_chk("t5_bad", mk(9, 1, 0));
        step(6);
        chk("t5_no_start", start_cnt, prev);
        chk("t5_err_set", err_bad_unit, 1);
        send_chk("t5_good", mk(0, 3, 1));
        wait_start(prev, 10, "t5_good_start");
        chk("t5_good_vec", last_start_vec, 4'b0001);
        chk("t5_err_sticky", err_bad_unit, 1);
        pulse_done(4'b0001);
        step(2);

        // 6: reset mid-operation
        prev = start_cnt;
        send_chk("t6_first", mk(2, 3, 0));
        wait_start(prev, 10, "t6_first_start");
        for (int k = 0; k < 4; k++) send_chk("t6_fill", mk(2, 1, k));
        step(4);
        chk("t6_level_3", fifo_level, 3);
        chk("t6_busy_u2", unit_busy, 4'b0100);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("t6_rst_start", unit_start, 0);
        chk("t6_rst_busy", unit_busy, 0);
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_s_ready", s_ready, 1);
        chk("t6_rst_err", err_bad_unit, 0);
        chk("t6_rst_sync", sync_done, 0);
        chk("t6_rst_op", unit_op, 0);
        chk("t6_rst_comp", unit_comp, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1);
        prev = start_cnt;
        pulse_done(4'b0100);
        step(6);
        chk("t6_late_done_ignored", unit_busy, 0);
        chk("t6_no_start", start_cnt, prev);
        chk("t6_level_empty", fifo_level, 0);

        // Random traffic with random completions and stray done pulses
        auto_en = 1;
        spur_en = 1;
        for (int i = 0; i < 300; i++) begin
            int r;
            int u;
            int op;
            step($urandom_range(0, 2));
            u = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            r = $urandom_range(0, 15);
            if (r < 9)       op = $urandom_range(1, 3);
            else if (r < 11) op = 4;
            else if (r < 12) op = 0;
            else             op = $urandom_range(5, 7);
            send(mk(u, op, $urandom_range(0, 7)), 400, ok);
            if (!ok) chk("rand_accept", ok, 1);
        end
        wait_drain(5000, "rand_drain");
        chk("rand_err_flag", err_bad_unit, bad_seen);
        auto_en = 0;
        spur_en = 0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
